// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline control path: controller states and the
// instruction constants also used by the hazard detection unit.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } ctrl_state_t;

  // All-zero word decodes as sll $0,$0,0, so a cleared pipeline register is a NOP.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2b;

  function automatic logic is_mem_op(input logic [5:0] opcode);
    return (opcode == OPC_LW) || (opcode == OPC_SW);
  endfunction

endpackage

// File: rtl/pipeline_controller_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// Five-stage pipeline control: stall/flush/bubble generation for hazards,
// taken branches, multi-cycle memory accesses and halt, plus perf counters.
module pipeline_controller
  import pipeline_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 is_hazard_detected,
  input  logic                 branch_taken_ID,
  input  logic                 mem_req_MEM,
  input  logic                 mem_ready,
  input  logic                 halt_WB,
  output logic                 pc_write_en,
  output logic                 if_id_write_en,
  output logic                 if_id_flush,
  output logic                 id_exe_bubble,
  output logic                 exe_mem_write_en,
  output logic                 mem_wb_bubble,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count,
  output logic                 halted,
  output logic                 mem_timeout
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  ctrl_state_t       state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              timeout_nxt;
  logic              mem_stall;

  // NOTE: every signal written here gets a default first, so no path through
  // the decision tree can leave one unassigned and infer a latch.
  always_comb begin
    pc_write_en      = 1'b1;
    if_id_write_en   = 1'b1;
    if_id_flush      = 1'b0;
    id_exe_bubble    = 1'b0;
    exe_mem_write_en = 1'b1;
    mem_wb_bubble    = 1'b0;
    state_nxt        = state;
    wait_cnt_nxt     = wait_cnt;
    timeout_nxt      = mem_timeout;
    // Once waiting, only mem_ready matters: the frozen MEM stage still holds the access.
    mem_stall        = (state == MEM_WAIT) ? !mem_ready : (mem_req_MEM && !mem_ready);

    if (!rst_n || (state == HALT)) begin
      pc_write_en      = 1'b0;
      if_id_write_en   = 1'b0;
      exe_mem_write_en = 1'b0;
    end else if (halt_WB) begin
      pc_write_en      = 1'b0;
      if_id_write_en   = 1'b0;
      exe_mem_write_en = 1'b0;
      state_nxt        = HALT;
    end else if (mem_stall) begin
      pc_write_en      = 1'b0;
      if_id_write_en   = 1'b0;
      exe_mem_write_en = 1'b0;
      mem_wb_bubble    = 1'b1;
      if (state == RUN) begin
        state_nxt    = MEM_WAIT;
        wait_cnt_nxt = WAIT_W'(1);
      end else if (wait_cnt >= WAIT_W'(MEM_TIMEOUT)) begin
        state_nxt   = HALT;
        timeout_nxt = 1'b1;
      end else begin
        wait_cnt_nxt = wait_cnt + WAIT_W'(1);
      end
    end else begin
      state_nxt    = RUN;
      wait_cnt_nxt = '0;
      if (is_hazard_detected) begin
        // ID is re-evaluated next cycle, so a branch seen now is not yet final.
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_exe_bubble  = 1'b1;
      end else if (branch_taken_ID) begin
        if_id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      mem_timeout <= timeout_nxt;
    end
  end

  assign halted = (state == HALT);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!pc_write_en && (state != HALT)),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (if_id_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench: a rule-level model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_pipeline_controller;

  localparam int CW   = 4;
  localparam int TO   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          is_hazard_detected, branch_taken_ID, mem_req_MEM, mem_ready, halt_WB;
  logic          pc_write_en, if_id_write_en, if_id_flush, id_exe_bubble;
  logic          exe_mem_write_en, mem_wb_bubble, halted, mem_timeout;
  logic [CW-1:0] stall_count, flush_count;

  int total = 0;
  int bad   = 0;

  // Model state: halted/timeout flags, consecutive frozen-memory cycles, counts.
  bit m_halted, m_timeout;
  int m_waited, m_stall, m_flush;

  pipeline_controller #(.CNT_WIDTH(CW), .MEM_TIMEOUT(TO)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .is_hazard_detected (is_hazard_detected),
    .branch_taken_ID    (branch_taken_ID),
    .mem_req_MEM        (mem_req_MEM),
    .mem_ready          (mem_ready),
    .halt_WB            (halt_WB),
    .pc_write_en        (pc_write_en),
    .if_id_write_en     (if_id_write_en),
    .if_id_flush        (if_id_flush),
    .id_exe_bubble      (id_exe_bubble),
    .exe_mem_write_en   (exe_mem_write_en),
    .mem_wb_bubble      (mem_wb_bubble),
    .stall_count        (stall_count),
    .flush_count        (flush_count),
    .halted             (halted),
    .mem_timeout        (mem_timeout)
  );

  always #5 clk = ~clk;

  // {pc_we, if_id_we, flush, id_exe_bubble, exe_mem_we, mem_wb_bubble}
  wire [5:0] outs = {pc_write_en, if_id_write_en, if_id_flush,
                     id_exe_bubble, exe_mem_write_en, mem_wb_bubble};

  localparam logic [5:0] O_IDLE   = 6'b110010;
  localparam logic [5:0] O_HAZARD = 6'b000110;
  localparam logic [5:0] O_BRANCH = 6'b111010;
  localparam logic [5:0] O_MEMW   = 6'b000001;
  localparam logic [5:0] O_OFF    = 6'b000000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_frozen();
    return !mem_ready && ((m_waited > 0) || mem_req_MEM);
  endfunction

  function automatic logic [5:0] model_outputs();
    if (m_halted || halt_WB)  return O_OFF;
    if (model_frozen())       return O_MEMW;
    if (is_hazard_detected)   return O_HAZARD;
    if (branch_taken_ID)      return O_BRANCH;
    return O_IDLE;
  endfunction

  task automatic model_reset();
    m_halted = 0; m_timeout = 0; m_waited = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_advance();
    logic [5:0] o;
    o = model_outputs();
    if (!m_halted && !o[5] && m_stall < CMAX) m_stall++;
    if (o[3] && m_flush < CMAX) m_flush++;
    if (m_halted) return;
    if (halt_WB) begin
      m_halted = 1;
    end else if (model_frozen()) begin
      m_waited++;
      if (m_waited > TO) begin
        m_halted  = 1;
        m_timeout = 1;
      end
    end else begin
      m_waited = 0;
    end
  endtask

  // Every-cycle comparison against the model, sampled mid-cycle.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        check("rst_outs", {26'd0, outs}, {26'd0, O_OFF});
      end else begin
        check("outs", {26'd0, outs}, {26'd0, model_outputs()});
      end
      check("halted", {31'd0, halted}, {31'd0, m_halted});
      check("mem_timeout", {31'd0, mem_timeout}, {31'd0, m_timeout});
      check("stall_count", {28'd0, stall_count}, m_stall);
      check("flush_count", {28'd0, flush_count}, m_flush);
      @(posedge clk);
      if (rst_n) model_advance();
    end
  end

  task automatic drive(input logic hz, input logic br, input logic mreq,
                       input logic mrdy, input logic hlt);
    @(posedge clk);
    #1;
    is_hazard_detected = hz;
    branch_taken_ID    = br;
    mem_req_MEM        = mreq;
    mem_ready          = mrdy;
    halt_WB            = hlt;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    {is_hazard_detected, branch_taken_ID, mem_req_MEM, mem_ready, halt_WB} = '0;
    #1;
    check("reset_immediate_outs", {26'd0, outs}, 32'd0);
    check("reset_immediate_halted", {31'd0, halted}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    {is_hazard_detected, branch_taken_ID, mem_req_MEM, mem_ready, halt_WB} = '0;
    #1;
    check("por_outs", {26'd0, outs}, 32'd0);
    do_reset();

    // Idle run: everything enabled.
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("idle_outs", {26'd0, outs}, {26'd0, O_IDLE});

    // Hazard with branch, then branch alone.
    drive(1, 1, 0, 0, 0);
    @(negedge clk);
    check("hz_br_outs", {26'd0, outs}, {26'd0, O_HAZARD});
    drive(0, 1, 0, 0, 0);
    @(negedge clk);
    check("br_outs", {26'd0, outs}, {26'd0, O_BRANCH});
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("hz_br_stalls", {28'd0, stall_count}, 32'd1);
    check("hz_br_flushes", {28'd0, flush_count}, 32'd1);

    // Zero-wait access does not stall.
    drive(0, 0, 1, 1, 0);
    @(negedge clk);
    check("zero_wait_outs", {26'd0, outs}, {26'd0, O_IDLE});

    // Three-cycle memory wait then release.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0);
      @(negedge clk);
      check("memwait_outs", {26'd0, outs}, {26'd0, O_MEMW});
    end
    drive(0, 0, 1, 1, 0);
    @(negedge clk);
    check("mem_release_outs", {26'd0, outs}, {26'd0, O_IDLE});
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("memwait_stalls", {28'd0, stall_count}, 32'd3);

    // Timeout with MEM_TIMEOUT=4: halted after 5 stalled cycles.
    do_reset();
    drive(0, 0, 1, 0, 0);
    repeat (4) @(negedge clk);
    check("pre_timeout_halted", {31'd0, halted}, 32'd0);
    repeat (2) @(negedge clk);
    check("timeout_flag", {31'd0, mem_timeout}, 32'd1);
    check("timeout_halted", {31'd0, halted}, 32'd1);
    check("timeout_outs", {26'd0, outs}, 32'd0);
    check("timeout_stalls", {28'd0, stall_count}, 32'd5);
    drive(0, 0, 1, 1, 0);
    @(negedge clk);
    check("timeout_stays", {31'd0, halted}, 32'd1);

    // Halt wins over hazard; no stall counting while halted.
    do_reset();
    drive(1, 0, 0, 0, 1);
    @(negedge clk);
    check("halt_outs", {26'd0, outs}, 32'd0);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0);
    @(negedge clk);
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_outs_after", {26'd0, outs}, 32'd0);
    check("halt_stalls", {28'd0, stall_count}, 32'd1);
    check("halt_flushes", {28'd0, flush_count}, 32'd0);

    // Async reset pulse in the middle of a memory wait.
    do_reset();
    drive(0, 0, 1, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    mem_req_MEM = 1'b0;
    #1;
    check("async_outs", {26'd0, outs}, 32'd0);
    check("async_stalls", {28'd0, stall_count}, 32'd0);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("async_post_outs", {26'd0, outs}, {26'd0, O_IDLE});
    check("async_post_stalls", {28'd0, stall_count}, 32'd0);
    check("async_post_halted", {31'd0, halted}, 32'd0);

    // Saturation of both 4-bit counters.
    do_reset();
    for (int i = 0; i < 20; i++) drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("sat_stalls", {28'd0, stall_count}, 32'd15);
    check("sat_flushes", {28'd0, flush_count}, 32'd15);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter CNT_WIDTH SHALL default to 32 and sets the width of both performance counters.
REQ-003 Parameter MEM_TIMEOUT SHALL default to 255 and sets the maximum consecutive MEM_WAIT cycles.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 is_hazard_detected  input  1  stall request from the hazard detection unit for the ID instruction.
REQ-007 branch_taken_ID  input  1  branch or jump in ID is resolved taken.
REQ-008 mem_req_MEM  input  1  load or store is present in the MEM stage.
REQ-009 mem_ready  input  1  data memory has completed the MEM-stage access.
REQ-010 halt_WB  input  1  syscall has retired in WB.
REQ-011 pc_write_en  output  1  PC register load enable.
REQ-012 if_id_write_en  output  1  IF/ID register load enable.
REQ-013 if_id_flush  output  1  clear IF/ID to a NOP.
REQ-014 id_exe_bubble  output  1  load a NOP into ID/EXE.
REQ-015 exe_mem_write_en  output  1  EXE/MEM register load enable.
REQ-016 mem_wb_bubble  output  1  load a NOP into MEM/WB.
REQ-017 stall_count  output  CNT_WIDTH  cycles with pc_write_en=0 outside HALT.
REQ-018 flush_count  output  CNT_WIDTH  cycles with if_id_flush=1.
REQ-019 halted  output  1  the controller is in HALT.
REQ-020 mem_timeout  output  1  sticky memory-timeout error.

Function
REQ-021 The FSM SHALL have three states: RUN, MEM_WAIT and HALT.
REQ-022 Outputs SHALL be Mealy, i.e. combinational from state and inputs; counters and flags SHALL be registered.
REQ-023 Default outputs in RUN with no events SHALL be: all write enables 1, flush 0, bubbles 0.
REQ-024 Priority (highest first) SHALL be: halt_WB, then memory wait, then hazard, then branch.
REQ-025 In RUN, halt_WB=1 SHALL drive all enables to 0 this cycle and move the FSM to HALT.
REQ-026 In RUN, mem_req_MEM=1 with mem_ready=0 SHALL:
- set pc_write_en, if_id_write_en and exe_mem_write_en to 0;
- set mem_wb_bubble to 1 and id_exe_bubble to 0;
- move the FSM to MEM_WAIT.
REQ-027 In RUN with no memory wait, is_hazard_detected=1 SHALL:
- set pc_write_en and if_id_write_en to 0;
- set id_exe_bubble to 1;
- force if_id_flush to 0, suppressing the branch because ID re-evaluates next cycle.
REQ-028 In RUN with no hazard, branch_taken_ID=1 SHALL assert if_id_flush for exactly that cycle, with pc_write_en=1.
REQ-029 In MEM_WAIT with mem_ready=0, the outputs SHALL stay as in REQ-026 and the wait counter SHALL increment.
REQ-030 In MEM_WAIT with mem_ready=1, the outputs SHALL follow the RUN rules (REQ-027/028), the FSM SHALL return to RUN, and the wait counter SHALL clear.
REQ-031 When the wait counter reaches MEM_TIMEOUT with mem_ready still 0, mem_timeout SHALL set and the FSM SHALL enter HALT on the next edge.
REQ-032 In HALT, all enables SHALL be 0, bubbles and flush 0, and halted=1; only reset exits HALT.
REQ-033 stall_count SHALL increment each cycle where pc_write_en=0 and state is not HALT, saturating at all-ones.
REQ-034 flush_count SHALL increment each cycle where if_id_flush=1, saturating at all-ones.
REQ-035 mem_req_MEM and mem_ready both 1 in RUN SHALL be a zero-wait access with no stall.

Reset
REQ-036 While rst_n=0, the block SHALL force:
- state to RUN;
- counters, the wait counter and mem_timeout to 0;
- all enables, bubbles and flush to 0, and halted to 0.
REQ-037 Reset assertion mid-MEM_WAIT or mid-HALT SHALL take effect immediately, with no clock required.

Structure
REQ-038 Package pipeline_pkg SHALL hold the ctrl_state_t enum (RUN, MEM_WAIT, HALT) and the NOP/opcode constants shared with the hazard detection unit.
REQ-039 A sub-module sat_counter (parameter WIDTH; ports clk, rst_n, inc, count) SHALL be instanced twice, for stall_count and flush_count.

Verification
REQ-040 Hazard then branch: is_hazard_detected=1 and branch_taken_ID=1 for 1 cycle, then branch only -> cycle 1: pc_write_en=0, id_exe_bubble=1, if_id_flush=0; cycle 2: if_id_flush=1; stall_count=1, flush_count=1.
REQ-041 Memory wait: mem_req_MEM=1 with mem_ready low for 3 cycles, then high -> 3 frozen cycles with mem_wb_bubble=1, release on cycle 4, stall_count=3.
REQ-042 Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout=1 and halted=1 after 5 cycles, with all enables 0 thereafter.
REQ-043 Halt: halt_WB=1 together with is_hazard_detected=1 -> HALT entered; stall_count not incremented in HALT.
REQ-044 Async reset: rst_n pulsed low mid-MEM_WAIT between clock edges -> outputs 0 immediately; state RUN and counters 0 after release.
REQ-045 Saturation: CNT_WIDTH=4, 20 hazard cycles -> stall_count=15.
